// File: rtl/fp32_sq_accum.sv
// Streaming sum-of-squares accumulator: aligns non-negative FP32 squares into a
// wide fixed-point register and emits the truncated FP32 total once per vector.
module fp32_sq_accum #(
  parameter int ACC_W     = 48,
  parameter int FRAC_BITS = 16,
  parameter int MAX_LEN   = 1024,
  parameter int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [2:0]       out_flags,
  output logic [1:0]       dbg_state
);

  // Handshake: a beat or result moves on a rising edge where valid && ready;
  // the source holds valid and its payload stable until that edge.

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_NORM = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   aligned_q;
  logic [CNT_W-1:0]   count;
  logic               s1_valid;
  logic               s1_end;
  logic               last_seen;
  logic               inf_nan_q;
  logic               acc_sat_q;
  logic               len_err_q;

  logic               accept;
  logic [7:0]         e;
  logic [ACC_W-1:0]   m_ext;
  int                 sh;
  logic [ACC_W-1:0]   aligned_d;
  logic               inf_d;
  logic               sat_d;
  logic [CNT_W-1:0]   count_nxt;
  logic               len_d;
  logic               end_d;
  logic [ACC_W:0]     sum_ext;

  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  always_comb begin
    aligned_d = '0;
    inf_d     = 1'b0;
    sat_d     = 1'b0;
    e         = in_data[30:23];
    m_ext     = ACC_W'({1'b1, in_data[22:0]});
    sh        = $signed({24'd0, e}) - 150 + FRAC_BITS;
    if (e == 8'd0) begin
      aligned_d = '0;
    end else if (e == 8'hFF) begin
      inf_d = 1'b1;
    end else if (sh > ACC_W - 24) begin
      aligned_d = '1;
      sat_d     = 1'b1;
    end else if (sh < -23) begin
      aligned_d = '0;
    end else if (sh < 0) begin
      aligned_d = m_ext >> (-sh);
    end else begin
      aligned_d = m_ext << sh;
    end
  end

  // A vector also ends when the beat counter would reach MAX_LEN.
  assign count_nxt = count + 1'b1;
  assign len_d     = !in_last && (count_nxt == CNT_W'(MAX_LEN));
  assign end_d     = in_last || len_d;
  assign sum_ext   = {1'b0, acc} + {1'b0, aligned_q};

  int          p;
  int          exp_i;
  logic [ACC_W-1:0] norm;
  logic [22:0] mant;
  logic [31:0] sum_d;

  always_comb begin
    p = 0;
    for (int i = 0; i < ACC_W; i++) begin
      if (acc[i]) p = i;
    end
    norm  = acc << (ACC_W - 1 - p);
    mant  = norm[ACC_W-2 -: 23];
    exp_i = p - FRAC_BITS + 127;
    if (acc == '0)                    sum_d = 32'h0000_0000;
    else if (inf_nan_q || acc_sat_q)  sum_d = 32'h7F80_0000;
    else if (exp_i <= 0)              sum_d = 32'h0000_0000;
    else if (exp_i >= 255)            sum_d = 32'h7F80_0000;
    else                              sum_d = {1'b0, 8'(exp_i), mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_ACC;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_flags <= '0;
      acc       <= '0;
      aligned_q <= '0;
      count     <= '0;
      s1_valid  <= 1'b0;
      s1_end    <= 1'b0;
      last_seen <= 1'b0;
      inf_nan_q <= 1'b0;
      acc_sat_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        aligned_q <= aligned_d;
        s1_end    <= end_d;
        count     <= count_nxt;
        if (inf_d) inf_nan_q <= 1'b1;
        if (sat_d) acc_sat_q <= 1'b1;
        if (len_d) len_err_q <= 1'b1;
        if (end_d) last_seen <= 1'b1;
      end
      if (s1_valid) begin
        if (sum_ext[ACC_W]) begin
          acc       <= '1;
          acc_sat_q <= 1'b1;
        end else begin
          acc <= sum_ext[ACC_W-1:0];
        end
      end
      case (state)
        S_ACC: begin
          if (accept && end_d) in_ready <= 1'b0;
          else if (!last_seen) in_ready <= 1'b1;
          if (s1_valid && s1_end) state <= S_NORM;
        end
        S_NORM: begin
          out_sum   <= sum_d;
          out_count <= count;
          out_flags <= {inf_nan_q, acc_sat_q, len_err_q};
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            inf_nan_q <= 1'b0;
            acc_sat_q <= 1'b0;
            len_err_q <= 1'b0;
            last_seen <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_sq_accum.sv
// Bench for fp32_sq_accum: directed cases plus random vectors scored against a
// real-arithmetic reference of the sum of squares.
module tb_fp32_sq_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready, sel_short;
  logic [31:0] in_data;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_out_sum, b_out_sum;
  logic [10:0] a_out_count;
  logic [2:0]  b_out_count;
  logic [2:0]  a_out_flags, b_out_flags;
  logic [1:0]  a_dbg, b_dbg;

  fp32_sq_accum dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && !sel_short), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready && !sel_short),
    .out_sum(a_out_sum), .out_count(a_out_count), .out_flags(a_out_flags),
    .dbg_state(a_dbg)
  );

  fp32_sq_accum #(.MAX_LEN(4)) dut_short (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid && sel_short), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready && sel_short),
    .out_sum(b_out_sum), .out_count(b_out_count), .out_flags(b_out_flags),
    .dbg_state(b_dbg)
  );

  logic        obs_ready, obs_valid;
  logic [31:0] obs_sum;
  logic [10:0] obs_count;
  logic [2:0]  obs_flags;
  assign obs_ready = sel_short ? b_in_ready  : a_in_ready;
  assign obs_valid = sel_short ? b_out_valid : a_out_valid;
  assign obs_sum   = sel_short ? b_out_sum   : a_out_sum;
  assign obs_count = sel_short ? {8'd0, b_out_count} : a_out_count;
  assign obs_flags = sel_short ? b_out_flags : a_out_flags;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] vec[$];
  logic [45:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact value of each square scaled by 2^16, floored, summed.
  function automatic logic [45:0] ref_result(input bit len_err);
    longint      sum = 0;
    bit          inf = 0, sat = 0;
    logic [31:0] res;
    logic [63:0] shv;
    int          p, ex;
    foreach (vec[i]) begin
      int e = int'(vec[i][30:23]);
      if (e == 255) inf = 1;
      else if (e != 0) begin
        real r = real'(int'({1'b1, vec[i][22:0]})) * (2.0 ** real'(e - 150)) * 65536.0;
        if (r >= 2.0 ** 48) sat = 1;
        else sum += longint'($floor(r));
      end
    end
    if (sum >= (longint'(1) << 48)) sat = 1;
    if (sat && sum == 0) sum = 1;
    if (sum == 0) res = 32'h0;
    else if (inf || sat) res = 32'h7F80_0000;
    else begin
      p = 0;
      for (int i = 0; i < 64; i++) if (sum[i]) p = i;
      ex  = p - 16 + 127;
      shv = 64'(sum) << (63 - p);
      res = (ex <= 0) ? 32'h0 : {1'b0, 8'(ex), shv[62:40]};
    end
    return {res, 11'(vec.size()), inf, sat, len_err};
  endfunction

  function automatic logic [31:0] rand_fp();
    int r = $urandom_range(0, 99);
    logic [7:0] e;
    if (r < 5)       e = 8'd0;
    else if (r < 8)  e = 8'hFF;
    else if (r < 12) e = 8'($urandom_range(155, 165));
    else             e = 8'($urandom_range(100, 150));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic l);
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!obs_ready && k < 50) begin @(negedge clk); k++; end
    if (!obs_ready) check("in_ready_wait", {63'd0, obs_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_vec(input bit with_last, input bit len_err, input bit gaps);
    foreach (vec[i]) begin
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
      send_beat(vec[i], with_last && (i == vec.size() - 1));
    end
    exp_q.push_back(ref_result(len_err));
  endtask

  task automatic collect(input string tag, input int hold);
    int k = 0;
    logic [31:0] s; logic [10:0] c; logic [2:0] f;
    logic [45:0] ex;
    @(negedge clk);
    while (!obs_valid && k < 50) begin @(negedge clk); k++; end
    check({tag, "_valid"}, {63'd0, obs_valid}, 64'd1);
    check({tag, "_in_ready_busy"}, {63'd0, obs_ready}, 64'd0);
    s = obs_sum; c = obs_count; f = obs_flags;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {obs_valid, obs_ready, f, c, s}, {1'b1, 1'b0, obs_flags, obs_count, obs_sum});
    end
    ex = exp_q.pop_front();
    check({tag, "_sum"},   {32'd0, s}, {32'd0, ex[45:14]});
    check({tag, "_count"}, {53'd0, c}, {53'd0, ex[13:3]});
    check({tag, "_flags"}, {61'd0, f}, {61'd0, ex[2:0]});
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_post_ready"}, {62'd0, obs_ready, obs_valid}, 64'd2);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; sel_short = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_flags, a_dbg}, 64'd0);
    rst_n = 1'b1;

    // 4 x 1.0 and latency check
    vec = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    send_vec(1, 0, 0);
    check("lat_T0", {63'd0, a_out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_T1", {63'd0, a_out_valid}, 64'd0);
    @(posedge clk); #1;
    check("lat_T2", {63'd0, a_out_valid}, 64'd1);
    check("t1_sum_const", {32'd0, a_out_sum}, 64'h4080_0000);
    collect("t1", 0);

    vec = '{32'h3F80_0000, 32'h4010_0000, 32'h0000_0000};
    send_vec(1, 0, 0); collect("t2", 0);
    check("t2_sum_const", {32'd0, a_out_sum}, 64'h4050_0000);

    vec = '{32'h3700_0000, 32'h3700_0000}; send_vec(1, 0, 0); collect("t3a", 0);
    vec = '{32'h4F00_0000};                send_vec(1, 0, 0); collect("t3b", 0);
    check("t3b_sum_const", {32'd0, a_out_sum}, 64'h4F00_0000);
    vec = '{32'h4F80_0000};                send_vec(1, 0, 0); collect("t3c", 0);
    check("t3c_flags_const", {61'd0, a_out_flags}, 64'd2);

    vec = '{32'h3F80_0000, 32'h7F80_0000, 32'h4000_0000}; send_vec(1, 0, 0); collect("t4a", 0);
    check("t4a_flags_const", {61'd0, a_out_flags}, 64'd4);

    sel_short = 1'b1;
    vec = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    send_vec(0, 1, 0); collect("t4b", 0);
    check("t4b_const", {b_out_sum, 21'd0, b_out_count, b_out_flags}, {32'h4080_0000, 21'd0, 3'd4, 3'b001});
    sel_short = 1'b0;

    vec = '{32'h4040_0000, 32'h3F00_0000}; send_vec(1, 0, 0); collect("t5", 5);
    vec = '{32'h3F80_0000}; send_vec(1, 0, 0); collect("t5_fresh", 0);

    // reset mid-vector
    send_beat(32'h3F80_0000, 1'b0);
    send_beat(32'h3F80_0000, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    check("t6_reset", {a_out_valid, a_in_ready, a_out_sum, a_out_count, a_out_flags}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    vec = '{32'h4000_0000}; send_vec(1, 0, 0); collect("t6", 0);

    for (int v = 0; v < 30; v++) begin
      int n = $urandom_range(1, 8);
      vec = {};
      for (int i = 0; i < n; i++) vec.push_back(rand_fp());
      send_vec(1, 0, 1);
      collect("rnd", $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
